sound_synth: RTL and testbench

//  Parametrised multi-channel tone/noise generator for the audio path; successor to the fixed 4-channel switch-driven generator.
//  NUM_CH channels, each with period, duty, volume, decay envelope and LFSR noise mode, programmed via a byte-wide register write port.

---
 rtl/sound_synth.sv | 142 ++++++++++++++
 tb/tb_sound_synth.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sound_synth.sv
// Multi-channel tone/noise generator: per-channel period, duty, volume, decay
// envelope and LFSR noise, mixed into a signed sample registered on sample_tick.
module sound_synth #(
    parameter int NUM_CH     = 4,
    parameter int PERIOD_W   = 16,
    parameter int VOL_W      = 5,
    parameter int SAMPLE_W   = 24,
    parameter int PERIOD_RST = 14205,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [2:0]          wr_reg,
    input  logic [7:0]          wr_data,
    input  logic                sample_tick,
    output logic [SAMPLE_W-1:0] sample,
    output logic                sample_valid,
    output logic [NUM_CH-1:0]   ch_active
);

    localparam int AMP_SHIFT = SAMPLE_W - 1 - VOL_W - CH_W;

    typedef enum logic [2:0] {
        REG_PER_LO = 3'd0,
        REG_PER_HI = 3'd1,
        REG_VOLUME = 3'd2,
        REG_DUTY   = 3'd3,
        REG_DECAY  = 3'd4,
        REG_CTRL   = 3'd5
    } reg_sel_e;

    logic                wr_ok;
    logic [SAMPLE_W-1:0] ch_val [NUM_CH];
    logic [NUM_CH-1:0]   active_now;
    logic [SAMPLE_W-1:0] mix;

    assign wr_ok = wr_en && ({1'b0, wr_ch} < (CH_W+1)'(NUM_CH));

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [PERIOD_W-1:0] period;
        logic [PERIOD_W-1:0] phase;
        logic [2:0]          duty;
        logic [2:0]          step;
        logic [VOL_W-1:0]    volume;
        logic [VOL_W-1:0]    level;
        logic [7:0]          decay;
        logic [7:0]          env_cnt;
        logic                enable;
        logic [14:0]         lfsr;
        logic                sel;
        logic                key_on;
        logic                high;
        logic [SAMPLE_W-1:0] amp;

        assign sel    = wr_ok && (wr_ch == CH_W'(g));
        assign key_on = sel && (wr_reg == REG_CTRL) && wr_data[1];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                period  <= PERIOD_W'(PERIOD_RST);
                duty    <= 3'd3;
                volume  <= '0;
                level   <= '0;
                decay   <= '0;
                enable  <= 1'b1;
                phase   <= '0;
                step    <= '0;
                env_cnt <= '0;
                lfsr    <= '1;
            end else begin
                if (key_on) begin
                    phase   <= '0;
                    step    <= '0;
                    lfsr    <= '1;
                    level   <= volume;
                    env_cnt <= '0;
                end else begin
                    // >= so a period shrunk below the current phase ends the step next clk
                    if (enable) begin
                        if (phase >= period) begin
                            phase <= '0;
                            step  <= step + 3'd1;
                            lfsr  <= {lfsr[0] ^ lfsr[1], lfsr[14:1]};
                        end else begin
                            phase <= phase + PERIOD_W'(1);
                        end
                    end
                    if (sample_tick && enable && (decay != 8'd0)) begin
                        if (env_cnt + 8'd1 == decay) begin
                            env_cnt <= '0;
                            if (level != '0)
                                level <= level - VOL_W'(1);
                        end else begin
                            env_cnt <= env_cnt + 8'd1;
                        end
                    end
                end
                if (sel) begin
                    case (wr_reg)
                        REG_PER_LO: period[7:0]          <= wr_data;
                        REG_PER_HI: period[PERIOD_W-1:8] <= wr_data[PERIOD_W-9:0];
                        REG_VOLUME: begin
                            volume <= wr_data[VOL_W-1:0];
                            level  <= wr_data[VOL_W-1:0];
                        end
                        REG_DUTY:   duty   <= wr_data[2:0];
                        REG_DECAY:  decay  <= wr_data;
                        REG_CTRL:   enable <= wr_data[0];
                        default: ;
                    endcase
                end
            end
        end

        assign high          = (duty == 3'd7) ? lfsr[0] : (step <= duty);
        assign amp           = SAMPLE_W'(level) << AMP_SHIFT;
        assign ch_val[g]     = !enable ? '0 : (high ? amp : ('0 - amp));
        assign active_now[g] = enable && (level != '0);
    end

    always_comb begin
        mix = '0;
        for (int unsigned i = 0; i < NUM_CH; i++)
            mix = mix + ch_val[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample       <= '0;
            sample_valid <= 1'b0;
            ch_active    <= '0;
        end else begin
            sample_valid <= sample_tick;
            if (sample_tick)
                sample <= mix;
            ch_active <= active_now;
        end
    end

endmodule

// File: tb/tb_sound_synth.sv
// Bench for sound_synth: behavioural channel model feeding a sample scoreboard,
// plus directed checks of tone timing, mixing, envelope, noise and enable.
module tb_sound_synth;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [1:0]  wr_ch;
    logic [2:0]  wr_reg;
    logic [7:0]  wr_data;
    logic        sample_tick;
    logic [23:0] sample;
    logic        sample_valid;
    logic [3:0]  ch_active;

    int n_checks = 0;
    int n_fail   = 0;

    sound_synth #(
        .NUM_CH    (4),
        .PERIOD_W  (16),
        .VOL_W     (5),
        .SAMPLE_W  (24),
        .PERIOD_RST(14205)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_ch       (wr_ch),
        .wr_reg      (wr_reg),
        .wr_data     (wr_data),
        .sample_tick (sample_tick),
        .sample      (sample),
        .sample_valid(sample_valid),
        .ch_active   (ch_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model state
    int m_period[4], m_duty[4], m_vol[4], m_level[4], m_decay[4];
    int m_en[4], m_phase[4], m_step[4], m_env[4], m_lfsr[4];
    logic [3:0]  m_act;
    logic [23:0] sb[$];

    logic       c_valid, c_en, c_tick;
    logic [1:0] c_ch;
    logic [2:0] c_reg;
    logic [7:0] c_data;

    always @(posedge clk) begin
        c_valid <= rst_n;
        c_en    <= wr_en;
        c_ch    <= wr_ch;
        c_reg   <= wr_reg;
        c_data  <= wr_data;
        c_tick  <= sample_tick;
    end

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_period[i] = 14205; m_duty[i] = 3; m_vol[i] = 0; m_level[i] = 0;
            m_decay[i] = 0; m_en[i] = 1; m_phase[i] = 0; m_step[i] = 0;
            m_env[i] = 0; m_lfsr[i] = 'h7FFF;
        end
        m_act = '0;
        sb.delete();
    endtask

    task automatic model_step();
        int  sum;
        int  hi;
        bit  sel, key;
        sum = 0;
        for (int i = 0; i < 4; i++) begin
            if (m_en[i] != 0) begin
                hi = (m_duty[i] == 7) ? (m_lfsr[i] & 1) : ((m_step[i] <= m_duty[i]) ? 1 : 0);
                sum += (hi != 0) ? (m_level[i] << 16) : -(m_level[i] << 16);
            end
        end
        if (c_tick) sb.push_back(sum[23:0]);
        for (int i = 0; i < 4; i++)
            m_act[i] = (m_en[i] != 0) && (m_level[i] != 0);
        for (int i = 0; i < 4; i++) begin
            sel = c_en && (int'(c_ch) == i);
            key = sel && (c_reg == 3'd5) && c_data[1];
            if (key) begin
                m_phase[i] = 0; m_step[i] = 0; m_lfsr[i] = 'h7FFF;
                m_level[i] = m_vol[i]; m_env[i] = 0;
            end else begin
                if (m_en[i] != 0) begin
                    if (m_phase[i] >= m_period[i]) begin
                        m_phase[i] = 0;
                        m_step[i]  = (m_step[i] + 1) % 8;
                        m_lfsr[i]  = (m_lfsr[i] >> 1) | (((m_lfsr[i] ^ (m_lfsr[i] >> 1)) & 1) << 14);
                    end else begin
                        m_phase[i]++;
                    end
                end
                if (c_tick && m_en[i] != 0 && m_decay[i] != 0) begin
                    if (((m_env[i] + 1) & 255) == m_decay[i]) begin
                        m_env[i] = 0;
                        if (m_level[i] > 0) m_level[i]--;
                    end else begin
                        m_env[i] = (m_env[i] + 1) & 255;
                    end
                end
            end
            if (sel) begin
                case (c_reg)
                    3'd0: m_period[i] = (m_period[i] & 'hFF00) | int'(c_data);
                    3'd1: m_period[i] = (m_period[i] & 'h00FF) | (int'(c_data) << 8);
                    3'd2: begin m_vol[i] = int'(c_data) & 31; m_level[i] = m_vol[i]; end
                    3'd3: m_duty[i]  = int'(c_data) & 7;
                    3'd4: m_decay[i] = int'(c_data);
                    3'd5: m_en[i]    = int'(c_data) & 1;
                    default: ;
                endcase
            end
        end
    endtask

    always @(negedge clk) begin
        logic [23:0] exp_s;
        if (!rst_n) begin
            model_reset();
        end else begin
            if (c_valid) model_step();
            check("sample_valid", {31'd0, sample_valid}, {31'd0, sb.size() != 0});
            if (sb.size() != 0) begin
                exp_s = sb.pop_front();
                if (sample_valid) check("sb_sample", {8'd0, sample}, {8'd0, exp_s});
            end
            check("ch_active", {28'd0, ch_active}, {28'd0, m_act});
        end
    end

    task automatic wr(input int ch, input int r, input int d);
        wr_en = 1'b1; wr_ch = ch[1:0]; wr_reg = r[2:0]; wr_data = d[7:0];
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic tick();
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // key ch2 in noise mode and compare 20 back-to-back samples to an LFSR from 7FFF
    task automatic run_noise(input string tag);
        int l;
        l = 'h7FFF;
        wr(2, 5, 3);
        sample_tick = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check(tag, {8'd0, sample}, ((l & 1) != 0) ? 32'h1F0000 : 32'hE10000);
            l = (l >> 1) | (((l ^ (l >> 1)) & 1) << 14);
        end
        sample_tick = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        int lvl[7];
        lvl = '{3, 3, 2, 2, 1, 1, 0};
        rst_n = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_reg = '0; wr_data = '0; sample_tick = 1'b0;
        #12 rst_n = 1'b1;
        @(negedge clk);
        check("rst_sample", {8'd0, sample}, 32'h0);
        check("rst_valid", {31'd0, sample_valid}, 32'h0);
        check("rst_active", {28'd0, ch_active}, 32'h0);

        // ch0 square, period 3: 16 clk high / 16 clk low
        wr(0, 0, 3); wr(0, 1, 0); wr(0, 3, 3); wr(0, 2, 31); wr(0, 5, 3);
        tick();      check("sq_n0",  {8'd0, sample}, 32'h1F0000);
        idle(14);
        tick();      check("sq_n15", {8'd0, sample}, 32'h1F0000);
        tick();      check("sq_n16", {8'd0, sample}, 32'hE10000);
        idle(14);
        tick();      check("sq_n31", {8'd0, sample}, 32'hE10000);
        tick();      check("sq_n32", {8'd0, sample}, 32'h1F0000);

        // all channels full volume, long period
        for (int c = 0; c < 4; c++) begin
            wr(c, 0, 'hFF); wr(c, 1, 'hFF); wr(c, 3, 3); wr(c, 2, 31);
        end
        for (int c = 0; c < 4; c++) wr(c, 5, 3);
        tick();
        check("mix4", {8'd0, sample}, 32'h7C0000);
        check("mix4_active", {28'd0, ch_active}, 32'hF);

        // ch1 envelope decay
        wr(0, 2, 0); wr(2, 2, 0); wr(3, 2, 0);
        wr(1, 2, 3); wr(1, 4, 2); wr(1, 5, 3);
        for (int k = 0; k < 7; k++) begin
            tick();
            check("env_level", {8'd0, sample}, 32'(lvl[k]) << 16);
        end
        idle(2);
        check("env_inactive", {31'd0, ch_active[1]}, 32'h0);
        tick(); tick();
        check("env_floor", {8'd0, sample}, 32'h0);

        // ch2 noise, restarted by a second key_on
        wr(2, 0, 0); wr(2, 1, 0); wr(2, 3, 7); wr(2, 2, 31);
        run_noise("noise1");
        idle(7);
        run_noise("noise2");

        // ch0 enable freeze / resume
        wr(2, 2, 0);
        wr(0, 0, 3); wr(0, 1, 0); wr(0, 2, 31); wr(0, 5, 3);
        idle(5);
        wr(0, 5, 0);
        tick();
        check("off_sample", {8'd0, sample}, 32'h0);
        check("off_active", {31'd0, ch_active[0]}, 32'h0);
        idle(8);
        wr(0, 5, 1);
        idle(9);
        tick();      check("resume_n15", {8'd0, sample}, 32'h1F0000);
        tick();      check("resume_n16", {8'd0, sample}, 32'hE10000);

        // asynchronous reset mid-note
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("arst_sample", {8'd0, sample}, 32'h0);
        check("arst_valid", {31'd0, sample_valid}, 32'h0);
        check("arst_active", {28'd0, ch_active}, 32'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        wr(0, 2, 31); wr(0, 5, 3);
        tick();
        check("post_rst_duty", {8'd0, sample}, 32'h1F0000);
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
